// File: rtl/nmr_pkg.sv
// Shared encodings for the N-modular-redundant ALU pipeline: ALU op codes,
// health states and the width of the per-replica mismatch counters.
package nmr_pkg;

  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_OR  = 2'b01;
  localparam logic [1:0] ALU_ADD = 2'b10;
  localparam logic [1:0] ALU_SLT = 2'b11;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    HEALTH_NORMAL   = 2'b00,
    HEALTH_DEGRADED = 2'b01,
    HEALTH_FAILED   = 2'b10
  } health_e;

endpackage

// File: rtl/nmr_alu_core.sv
// One combinational ALU replica: and/or/add-sub/set-on-MSB with a zero flag.
module nmr_alu_core
  import nmr_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alucont,
  output logic [WIDTH-1:0] res,
  output logic             zero
);

  logic [WIDTH-1:0] b2;
  logic [WIDTH-1:0] sum;

  always_comb begin
    b2  = alucont[2] ? ~b : b;
    // carry-in of alucont[2] turns the inverted b into a two's complement subtract
    sum = a + b2 + {{(WIDTH-1){1'b0}}, alucont[2]};
    res = '0;
    case (alucont[1:0])
      ALU_AND: res = a & b;
      ALU_OR:  res = a | b;
      ALU_ADD: res = sum;
      ALU_SLT: res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1]};
      default: res = '0;
    endcase
    zero = (res == '0);
  end

endmodule

// File: rtl/nmr_alu_pipe.sv
// Replicated ALU with per-bit majority vote over live replicas, mismatch-driven
// replica retirement and a registered valid/ready output stage.
// Optional NMR_FAULT_INJECT_EN adds inj_mask/inj_xor to corrupt chosen replicas.
module nmr_alu_pipe
  import nmr_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int REPLICAS     = 9,
  parameter int FAULT_THRESH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic [2:0]          alucont,
`ifdef NMR_FAULT_INJECT_EN
  input  logic [REPLICAS-1:0] inj_mask,
  input  logic [WIDTH-1:0]    inj_xor,
`endif
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    result,
  output logic                zero,
  output logic [REPLICAS-1:0] active_mask,
  output logic [1:0]          health
);

  localparam logic [CNT_W-1:0] THRESH = CNT_W'(FAULT_THRESH);

  logic [WIDTH-1:0]    core_res [REPLICAS];
  logic [REPLICAS-1:0] core_zero;
  logic [WIDTH-1:0]    rep_res  [REPLICAS];
  logic [REPLICAS-1:0] rep_zero;

  logic [WIDTH-1:0]    vote_res;
  logic                vote_zero;
  logic [REPLICAS-1:0] mismatch;
  logic                accept;

  logic [CNT_W-1:0]    cnt_q [REPLICAS];
  logic [CNT_W-1:0]    cnt_d [REPLICAS];
  logic [REPLICAS-1:0] active_q, active_d;
  health_e             health_q, health_d;
  logic                out_valid_q, out_valid_d;
  logic [WIDTH-1:0]    result_q, result_d;
  logic                zero_q, zero_d;

  for (genvar i = 0; i < REPLICAS; i++) begin : g_rep
    nmr_alu_core #(.WIDTH(WIDTH)) u_core (
      .a       (a),
      .b       (b),
      .alucont (alucont),
      .res     (core_res[i]),
      .zero    (core_zero[i])
    );
`ifdef NMR_FAULT_INJECT_EN
    assign rep_res[i]  = core_res[i] ^ (inj_mask[i] ? inj_xor : '0);
    assign rep_zero[i] = inj_mask[i] ? (rep_res[i] == '0) : core_zero[i];
`else
    assign rep_res[i]  = core_res[i];
    assign rep_zero[i] = core_zero[i];
`endif
  end

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Strict majority over live replicas; an even split votes 0.
  always_comb begin
    int act_cnt;
    int ones;
    act_cnt = 0;
    for (int i = 0; i < REPLICAS; i++) if (active_q[i]) act_cnt++;
    vote_res = '0;
    for (int j = 0; j < WIDTH; j++) begin
      ones = 0;
      for (int i = 0; i < REPLICAS; i++) if (active_q[i] && rep_res[i][j]) ones++;
      vote_res[j] = (2 * ones > act_cnt);
    end
    ones = 0;
    for (int i = 0; i < REPLICAS; i++) if (active_q[i] && rep_zero[i]) ones++;
    vote_zero = (2 * ones > act_cnt);
    for (int i = 0; i < REPLICAS; i++)
      mismatch[i] = active_q[i] && ((rep_res[i] != vote_res) || (rep_zero[i] != vote_zero));
  end

  always_comb begin
    int act_next;
    active_d = active_q;
    for (int i = 0; i < REPLICAS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (accept && mismatch[i]) begin
        if (cnt_q[i] != '1) cnt_d[i] = cnt_q[i] + 1'b1;
        if (cnt_d[i] >= THRESH) active_d[i] = 1'b0;
      end
    end
    act_next = 0;
    for (int i = 0; i < REPLICAS; i++) if (active_d[i]) act_next++;
    health_d = health_q;
    if (health_q != HEALTH_FAILED) begin
      if (act_next < 3)          health_d = HEALTH_FAILED;
      else if (active_d != '1)   health_d = HEALTH_DEGRADED;
      else                       health_d = HEALTH_NORMAL;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    if (accept) begin
      out_valid_d = 1'b1;
      result_d    = vote_res;
      zero_d      = vote_zero;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      active_q    <= '1;
      health_q    <= HEALTH_NORMAL;
      for (int i = 0; i < REPLICAS; i++) cnt_q[i] <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      active_q    <= active_d;
      health_q    <= health_d;
      for (int i = 0; i < REPLICAS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign out_valid   = out_valid_q;
  assign result      = result_q;
  assign zero        = zero_q;
  assign active_mask = active_q;
  assign health      = health_q;

endmodule
